wb: RTL and testbench

- Fifth (write-back) stage of the five-stage MIPS pipeline.
- Consumes the 118-bit MEM->WB bus and drives the register-file write port.
- Owns the architectural HI/LO registers and a minimal CP0 (Count, Status, Cause, EPC).
- Resolves SYSCALL/ERET into a one-cycle redirect/flush to fetch.

---
 rtl/wb_pkg.sv | 34 +++
 rtl/wb_cp0_regs.sv | 91 +++++++++
 rtl/wb.sv | 95 +++++++++
 tb/tb_wb.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared definitions for the write-back stage: MEM->WB bus layout,
// CP0 register addresses and exception codes.
package wb_pkg;

    localparam int MEM_WB_W  = 118;
    localparam int EXC_BUS_W = 33;

    // CP0 addresses are {rd, sel}
    localparam logic [7:0] CP0_COUNT  = 8'h48;
    localparam logic [7:0] CP0_STATUS = 8'h60;
    localparam logic [7:0] CP0_CAUSE  = 8'h68;
    localparam logic [7:0] CP0_EPC    = 8'h70;

    localparam logic [4:0] EXC_SYS = 5'd8;

    // Field order matches the bus, MSB first
    typedef struct packed {
        logic        rf_wen;
        logic [4:0]  rf_wdest;
        logic [31:0] mem_result;
        logic [31:0] lo_result;
        logic        hi_write;
        logic        lo_write;
        logic        mfhi;
        logic        mflo;
        logic        mtc0;
        logic        mfc0;
        logic [7:0]  cp0r_addr;
        logic        syscall;
        logic        eret;
        logic [31:0] pc;
    } mem_wb_t;

endpackage

// File: rtl/wb_cp0_regs.sv
// Minimal CP0: Count, Status, Cause, EPC with MTC0 writes, MFC0 read mux
// and SYSCALL/ERET side effects.
module cp0_regs
    import wb_pkg::*;
#(
    parameter bit COUNT_EN = 1'b1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        mtc0_wen,
    input  logic [7:0]  cp0_addr,
    input  logic [31:0] wdata,
    input  logic        syscall_fire,
    input  logic        eret_fire,
    input  logic [31:0] pc,
    output logic [31:0] rdata,
    output logic [31:0] status,
    output logic [31:0] cause,
    output logic [31:0] epc
);

    logic [31:0] count_r, status_r, cause_r, epc_r;
    logic [31:0] count_mtc_s, status_mtc_s, cause_mtc_s, epc_mtc_s;
    logic [31:0] status_nxt_s, cause_nxt_s, epc_nxt_s;

    // MTC0 stage: software writes on top of the free-running Count
    always_comb begin
        count_mtc_s  = COUNT_EN ? (count_r + 32'd1) : count_r;
        status_mtc_s = status_r;
        cause_mtc_s  = cause_r;
        epc_mtc_s    = epc_r;
        if (mtc0_wen) begin
            case (cp0_addr)
                CP0_COUNT:  count_mtc_s  = wdata;
                CP0_STATUS: status_mtc_s = wdata;
                CP0_CAUSE:  cause_mtc_s  = {cause_r[31:10], wdata[9:8], cause_r[7:0]};
                CP0_EPC:    epc_mtc_s    = wdata;
                default:    epc_mtc_s    = epc_r;
            endcase
        end else begin
            epc_mtc_s = epc_r;
        end
    end

    // Exception stage: SYSCALL/ERET override MTC0 on the fields they own
    always_comb begin
        status_nxt_s = status_mtc_s;
        cause_nxt_s  = cause_mtc_s;
        epc_nxt_s    = epc_mtc_s;
        if (syscall_fire) begin
            epc_nxt_s        = pc;
            cause_nxt_s[6:2] = EXC_SYS;
            status_nxt_s[1]  = 1'b1;
        end else if (eret_fire) begin
            status_nxt_s[1] = 1'b0;
        end else begin
            status_nxt_s = status_mtc_s;
        end
    end

    // CP0 state; Count runs every cycle, the rest only on retire
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count_r  <= 32'h0000_0000;
            status_r <= 32'h0000_0000;
            cause_r  <= 32'h0000_0000;
            epc_r    <= 32'h0000_0000;
        end else begin
            count_r  <= count_mtc_s;
            status_r <= status_nxt_s;
            cause_r  <= cause_nxt_s;
            epc_r    <= epc_nxt_s;
        end
    end

    // MFC0 read mux, unmapped addresses read as zero
    always_comb begin
        case (cp0_addr)
            CP0_COUNT:  rdata = count_r;
            CP0_STATUS: rdata = status_r;
            CP0_CAUSE:  rdata = cause_r;
            CP0_EPC:    rdata = epc_r;
            default:    rdata = 32'h0000_0000;
        endcase
    end

    assign status = status_r;
    assign cause  = cause_r;
    assign epc    = epc_r;

endmodule

// File: rtl/wb.sv
// Write-back stage: register-file write port, HI/LO, CP0 and the
// SYSCALL/ERET redirect to fetch.
module wb
    import wb_pkg::*;
#(
    parameter logic [31:0] EXC_ENTRY = 32'h0000_0000,
    parameter bit          COUNT_EN  = 1'b1
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 WB_valid,
    input  logic [MEM_WB_W-1:0]  MEM_WB_bus_r,
    output logic                 rf_wen,
    output logic [4:0]           rf_wdest,
    output logic [31:0]          rf_wdata,
    output logic                 WB_over,
    output logic [4:0]           WB_wdest,
    output logic                 WB_bypass_valid,
    output logic [31:0]          WB_bypass_value,
    output logic [EXC_BUS_W-1:0] exc_bus,
    output logic                 cancel,
    output logic [31:0]          HI_data,
    output logic [31:0]          LO_data,
    output logic [31:0]          cp0r_status,
    output logic [31:0]          cp0r_cause,
    output logic [31:0]          cp0r_epc,
    output logic [31:0]          WB_pc
);

    mem_wb_t     bus_s;
    logic [31:0] hi_r, lo_r;
    logic [31:0] cp0_rdata_s, epc_s, wdata_s;
    logic        sys_s, eret_s, exc_valid_s;

    assign bus_s = MEM_WB_bus_r;

    // SYSCALL wins over an illegal SYSCALL+ERET encoding
    assign sys_s       = WB_valid & bus_s.syscall;
    assign eret_s      = WB_valid & bus_s.eret & ~bus_s.syscall;
    assign exc_valid_s = (sys_s | eret_s) & resetn;

    cp0_regs #(.COUNT_EN(COUNT_EN)) u_cp0 (
        .clk          (clk),
        .resetn       (resetn),
        .mtc0_wen     (WB_valid & bus_s.mtc0),
        .cp0_addr     (bus_s.cp0r_addr),
        .wdata        (bus_s.mem_result),
        .syscall_fire (sys_s),
        .eret_fire    (eret_s),
        .pc           (bus_s.pc),
        .rdata        (cp0_rdata_s),
        .status       (cp0r_status),
        .cause        (cp0r_cause),
        .epc          (epc_s)
    );

    // HI/LO update on retire; MULT may write both
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hi_r <= 32'h0000_0000;
            lo_r <= 32'h0000_0000;
        end else if (WB_valid) begin
            if (bus_s.hi_write) hi_r <= bus_s.mem_result;
            if (bus_s.lo_write) lo_r <= bus_s.lo_result;
        end
    end

    // Write-data source priority: HI, LO, CP0, then memory/ALU result
    always_comb begin
        if (bus_s.mfhi) begin
            wdata_s = hi_r;
        end else if (bus_s.mflo) begin
            wdata_s = lo_r;
        end else if (bus_s.mfc0) begin
            wdata_s = cp0_rdata_s;
        end else begin
            wdata_s = bus_s.mem_result;
        end
    end

    assign rf_wen          = bus_s.rf_wen & WB_valid & ~bus_s.syscall & ~bus_s.eret;
    assign rf_wdest        = bus_s.rf_wdest;
    assign rf_wdata        = wdata_s;
    assign WB_over         = WB_valid;
    assign WB_wdest        = bus_s.rf_wdest & {5{WB_valid}};
    assign WB_bypass_valid = WB_valid;
    assign WB_bypass_value = wdata_s;
    assign exc_bus         = {exc_valid_s, sys_s ? EXC_ENTRY : epc_s};
    assign cancel          = exc_valid_s;
    assign HI_data         = hi_r;
    assign LO_data         = lo_r;
    assign cp0r_epc        = epc_s;
    assign WB_pc           = bus_s.pc;

endmodule

// File: tb/tb_wb.sv
// Directed self-checking bench for the write-back stage.
module tb_wb;
    import wb_pkg::*;

    localparam logic [31:0] ENTRY = 32'h8000_0180;

    logic          clk, resetn, WB_valid;
    logic [117:0]  MEM_WB_bus_r;
    logic          rf_wen, WB_over, WB_bypass_valid, cancel;
    logic [4:0]    rf_wdest, WB_wdest;
    logic [31:0]   rf_wdata, WB_bypass_value, HI_data, LO_data;
    logic [31:0]   cp0r_status, cp0r_cause, cp0r_epc, WB_pc;
    logic [32:0]   exc_bus;
    mem_wb_t       b;
    int            checks = 0;
    int            errors = 0;

    wb #(.EXC_ENTRY(ENTRY), .COUNT_EN(1'b1)) dut (
        .clk(clk), .resetn(resetn), .WB_valid(WB_valid), .MEM_WB_bus_r(MEM_WB_bus_r),
        .rf_wen(rf_wen), .rf_wdest(rf_wdest), .rf_wdata(rf_wdata), .WB_over(WB_over),
        .WB_wdest(WB_wdest), .WB_bypass_valid(WB_bypass_valid),
        .WB_bypass_value(WB_bypass_value), .exc_bus(exc_bus), .cancel(cancel),
        .HI_data(HI_data), .LO_data(LO_data), .cp0r_status(cp0r_status),
        .cp0r_cause(cp0r_cause), .cp0r_epc(cp0r_epc), .WB_pc(WB_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic valid);
        WB_valid     = valid;
        MEM_WB_bus_r = b;
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        b = '0; b.syscall = 1'b1;
        drive(1'b1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (HI_data !== 32'h0) begin errors++; $display("FAIL reset_hi: got %h want 0", HI_data); end
        checks++; if (LO_data !== 32'h0) begin errors++; $display("FAIL reset_lo: got %h want 0", LO_data); end
        checks++; if ({cp0r_status, cp0r_cause, cp0r_epc} !== 96'h0) begin errors++; $display("FAIL reset_cp0: got %h %h %h want 0", cp0r_status, cp0r_cause, cp0r_epc); end
        checks++; if ({exc_bus[32], cancel} !== 2'b00) begin errors++; $display("FAIL reset_exc: got %b%b want 00", exc_bus[32], cancel); end
        b = '0; drive(1'b0);
        resetn = 1'b1;
        adv();
    endtask

    task automatic test_basic();
        b = '0; b.rf_wen = 1'b1; b.rf_wdest = 5'd3; b.mem_result = 32'h1234_5678;
        drive(1'b1);
        @(negedge clk);
        checks++; if ({rf_wen, rf_wdest, WB_wdest, WB_over} !== {1'b1, 5'd3, 5'd3, 1'b1}) begin errors++; $display("FAIL basic_ctrl: got wen=%b dest=%0d wdest=%0d over=%b want 1 3 3 1", rf_wen, rf_wdest, WB_wdest, WB_over); end
        checks++; if (rf_wdata !== 32'h1234_5678 || WB_bypass_value !== 32'h1234_5678) begin errors++; $display("FAIL basic_data: got %h/%h want 12345678", rf_wdata, WB_bypass_value); end
        drive(1'b0);
        #1;
        checks++; if ({rf_wen, WB_wdest, WB_bypass_valid} !== {1'b0, 5'd0, 1'b0}) begin errors++; $display("FAIL basic_invalid: got wen=%b wdest=%0d bv=%b want 0 0 0", rf_wen, WB_wdest, WB_bypass_valid); end
        adv();
    endtask

    task automatic test_hilo();
        b = '0; b.hi_write = 1'b1; b.lo_write = 1'b1;
        b.mem_result = 32'hAAAA_0001; b.lo_result = 32'h5555_0002;
        drive(1'b1); adv();
        b = '0; b.mfhi = 1'b1; b.rf_wen = 1'b1; b.rf_wdest = 5'd4; b.mem_result = 32'h0BAD_0BAD;
        drive(1'b1);
        @(negedge clk);
        checks++; if (rf_wdata !== 32'hAAAA_0001) begin errors++; $display("FAIL mfhi: got %h want aaaa0001", rf_wdata); end
        adv();
        b = '0; b.mflo = 1'b1; b.rf_wen = 1'b1; b.rf_wdest = 5'd5; b.mem_result = 32'h0BAD_0BAD;
        drive(1'b1);
        @(negedge clk);
        checks++; if (rf_wdata !== 32'h5555_0002 || rf_wdest !== 5'd5) begin errors++; $display("FAIL mflo: got %h dest %0d want 55550002 5", rf_wdata, rf_wdest); end
        checks++; if (HI_data !== 32'hAAAA_0001 || LO_data !== 32'h5555_0002) begin errors++; $display("FAIL hilo_regs: got %h %h want aaaa0001 55550002", HI_data, LO_data); end
        adv();
    endtask

    task automatic test_cp0();
        b = '0; b.mtc0 = 1'b1; b.cp0r_addr = CP0_STATUS; b.mem_result = 32'h0000_FF01;
        drive(1'b1); adv();
        b = '0; b.mfc0 = 1'b1; b.rf_wen = 1'b1; b.rf_wdest = 5'd6; b.cp0r_addr = CP0_STATUS;
        drive(1'b1);
        @(negedge clk);
        checks++; if (rf_wdata !== 32'h0000_FF01) begin errors++; $display("FAIL mfc0_status: got %h want 0000ff01", rf_wdata); end
        adv();
        b = '0; b.mtc0 = 1'b1; b.cp0r_addr = 8'h08; b.mem_result = 32'hDEAD_BEEF;
        drive(1'b1); adv();
        b = '0; b.mfc0 = 1'b1; b.cp0r_addr = 8'h08; b.mem_result = 32'h1111_1111;
        drive(1'b1);
        @(negedge clk);
        checks++; if ({cp0r_status, cp0r_cause, cp0r_epc} !== {32'h0000_FF01, 32'h0, 32'h0}) begin errors++; $display("FAIL mtc0_unmapped: got %h %h %h want 0000ff01 0 0", cp0r_status, cp0r_cause, cp0r_epc); end
        checks++; if (rf_wdata !== 32'h0) begin errors++; $display("FAIL mfc0_unmapped: got %h want 0", rf_wdata); end
        adv();
        b = '0; b.mtc0 = 1'b1; b.cp0r_addr = CP0_CAUSE; b.mem_result = 32'hFFFF_FFFF;
        drive(1'b1); adv();
        b = '0; drive(1'b0);
        @(negedge clk);
        checks++; if (cp0r_cause !== 32'h0000_0300) begin errors++; $display("FAIL mtc0_cause: got %h want 00000300", cp0r_cause); end
        adv();
    endtask

    task automatic test_syscall();
        b = '0; b.syscall = 1'b1; b.rf_wen = 1'b1; b.rf_wdest = 5'd7; b.pc = 32'hBFC0_0100;
        drive(1'b1);
        @(negedge clk);
        checks++; if (exc_bus !== {1'b1, ENTRY} || cancel !== 1'b1) begin errors++; $display("FAIL syscall_redirect: got %h cancel=%b want 1%h 1", exc_bus, cancel, ENTRY); end
        checks++; if (rf_wen !== 1'b0) begin errors++; $display("FAIL syscall_rfwen: got %b want 0", rf_wen); end
        adv();
        // syscall bit with WB_valid low must not fire
        drive(1'b0);
        @(negedge clk);
        checks++; if (cp0r_epc !== 32'hBFC0_0100) begin errors++; $display("FAIL syscall_epc: got %h want bfc00100", cp0r_epc); end
        checks++; if (cp0r_cause !== 32'h0000_0320 || cp0r_status !== 32'h0000_FF03) begin errors++; $display("FAIL syscall_cause_status: got %h %h want 00000320 0000ff03", cp0r_cause, cp0r_status); end
        checks++; if ({exc_bus[32], cancel} !== 2'b00) begin errors++; $display("FAIL syscall_idle: got %b%b want 00", exc_bus[32], cancel); end
        adv();
        b = '0; drive(1'b0);
        @(negedge clk);
        checks++; if (exc_bus[32] !== 1'b0) begin errors++; $display("FAIL idle_exc: got %b want 0", exc_bus[32]); end
        adv();
    endtask

    task automatic test_eret();
        b = '0; b.eret = 1'b1; b.pc = 32'h0000_4444;
        drive(1'b1);
        @(negedge clk);
        checks++; if (exc_bus !== {1'b1, 32'hBFC0_0100} || cancel !== 1'b1) begin errors++; $display("FAIL eret_redirect: got %h cancel=%b want 1bfc00100 1", exc_bus, cancel); end
        adv();
        b = '0; drive(1'b0);
        @(negedge clk);
        checks++; if (cp0r_status !== 32'h0000_FF01 || cancel !== 1'b0) begin errors++; $display("FAIL eret_status: got %h cancel=%b want 0000ff01 0", cp0r_status, cancel); end
        adv();
    endtask

    task automatic test_count_and_async_reset();
        b = '0; b.mtc0 = 1'b1; b.cp0r_addr = CP0_COUNT; b.mem_result = 32'hFFFF_FFFE;
        drive(1'b1); adv();
        b = '0; drive(1'b0); adv();
        b = '0; b.mfc0 = 1'b1; b.cp0r_addr = CP0_COUNT;
        drive(1'b1);
        @(negedge clk);
        checks++; if (rf_wdata !== 32'hFFFF_FFFF) begin errors++; $display("FAIL count_max: got %h want ffffffff", rf_wdata); end
        adv();
        @(negedge clk);
        checks++; if (rf_wdata !== 32'h0) begin errors++; $display("FAIL count_wrap: got %h want 0", rf_wdata); end
        adv();
        #2;
        resetn = 1'b0;
        #1;
        checks++; if ({HI_data, LO_data} !== 64'h0) begin errors++; $display("FAIL async_hilo: got %h %h want 0", HI_data, LO_data); end
        checks++; if ({cp0r_status, cp0r_cause, cp0r_epc, rf_wdata} !== 128'h0) begin errors++; $display("FAIL async_cp0: got %h %h %h count %h want 0", cp0r_status, cp0r_cause, cp0r_epc, rf_wdata); end
        @(negedge clk);
        resetn = 1'b1;
        b = '0; drive(1'b0);
        adv();
    endtask

    initial begin
        resetn = 1'b0;
        b = '0;
        WB_valid = 1'b0;
        MEM_WB_bus_r = '0;
        test_reset();
        test_basic();
        test_hilo();
        test_cp0();
        test_syscall();
        test_eret();
        test_count_and_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
